ffe_tap_scheduler: RTL and testbench

Sequencer for the time-multiplexed FFE datapath. It runs in the `ffe_clk` domain, where `ffe_clk` is NUM_TAPS times the symbol rate. Each accepted `load` strobe starts one equalizer output: the block steps the shared multiply-accumulate through every tap, supplies the matching coefficient, and flags the finished output. It also owns the coefficient register bank, programmed through a simple write/commit port.

---
 rtl/ffe_tap_scheduler.sv | 164 ++++++++++++++++
 tb/tb_ffe_tap_scheduler.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ffe_tap_scheduler.sv
// Tap sequencer and coefficient bank for the time-multiplexed FFE datapath.
// Define FFE_SCHED_SHADOW_EN for double-buffered coefficients with commit.
module ffe_tap_scheduler #(
  parameter int unsigned NUM_TAPS      = 4,
  parameter int unsigned TAP_IDX_WIDTH = 2,
  parameter int unsigned COEF_WIDTH    = 12
) (
  input  logic                         ffe_clk,
  input  logic                         rst,
  input  logic                         load,
  input  logic                         cfg_we,
  input  logic [TAP_IDX_WIDTH-1:0]     cfg_addr,
  input  logic signed [COEF_WIDTH-1:0] cfg_wdata,
  input  logic                         cfg_commit,
  input  logic                         ovf_clr,
  output logic                         shift_en,
  output logic [TAP_IDX_WIDTH-1:0]     tap_sel,
  output logic signed [COEF_WIDTH-1:0] coef,
  output logic                         acc_en,
  output logic                         acc_clr,
  output logic                         y_valid,
  output logic                         busy,
  output logic                         ovf,
  output logic                         commit_pending
);

  typedef enum logic {IDLE, RUN} state_t;
  typedef logic signed [COEF_WIDTH-1:0] coef_t;

  localparam coef_t                     COEF_ONE = coef_t'(1 << (COEF_WIDTH - 2));
  localparam logic [TAP_IDX_WIDTH-1:0]  LAST_TAP = TAP_IDX_WIDTH'(NUM_TAPS - 1);

  state_t                     state_q, state_d;
  logic [TAP_IDX_WIDTH-1:0]   tap_q, tap_d;
  logic                       acc_en_q, acc_en_d;
  logic                       acc_clr_q, acc_clr_d;
  logic                       y_valid_q, y_valid_d;
  logic                       ovf_q, ovf_d;
  coef_t                      coef_q;
  coef_t                      active_q [NUM_TAPS];
  coef_t                      active_d [NUM_TAPS];
  logic                       accept;
  logic                       at_last;

  assign at_last  = (state_q == RUN) && (tap_q == LAST_TAP);
  assign accept   = load && ((state_q == IDLE) || at_last);
  assign shift_en = accept;

  always_comb begin
    state_d   = state_q;
    tap_d     = tap_q;
    acc_en_d  = 1'b0;
    acc_clr_d = 1'b0;
    y_valid_d = at_last;
    if (accept) begin
      state_d   = RUN;
      tap_d     = '0;
      acc_en_d  = 1'b1;
      acc_clr_d = 1'b1;
    end else if (state_q == RUN) begin
      if (tap_q == LAST_TAP) begin
        state_d = IDLE;
        tap_d   = '0;
      end else begin
        tap_d    = tap_q + TAP_IDX_WIDTH'(1);
        acc_en_d = 1'b1;
      end
    end
  end

  // A dropped load sets ovf even if ovf_clr is asserted in the same cycle.
  always_comb begin
    ovf_d = ovf_q;
    if (load && !accept) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

`ifdef FFE_SCHED_SHADOW_EN
  coef_t shadow_q [NUM_TAPS];
  coef_t shadow_d [NUM_TAPS];
  logic  pend_q, pend_d;
  logic  commit_req;
  logic  do_copy;

  // Copies only at sample boundaries and from the pre-write shadow contents.
  assign commit_req = cfg_commit || pend_q;
  assign do_copy    = commit_req && ((state_q == IDLE) || at_last);

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    pend_d   = commit_req && !do_copy;
    if (cfg_we) begin
      shadow_d[cfg_addr] = cfg_wdata;
    end
    if (do_copy) begin
      active_d = shadow_q;
    end
  end

  always_ff @(posedge ffe_clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_TAPS; i++) begin
        shadow_q[i] <= (i == 0) ? COEF_ONE : '0;
      end
      pend_q <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
    end
  end

  assign commit_pending = pend_q;
`else
  logic unused_commit;

  assign unused_commit = cfg_commit;

  always_comb begin
    active_d = active_q;
    if (cfg_we) begin
      active_d[cfg_addr] = cfg_wdata;
    end
  end

  assign commit_pending = 1'b0;
`endif

  always_ff @(posedge ffe_clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      tap_q     <= '0;
      acc_en_q  <= 1'b0;
      acc_clr_q <= 1'b0;
      y_valid_q <= 1'b0;
      ovf_q     <= 1'b0;
      coef_q    <= COEF_ONE;
      for (int unsigned i = 0; i < NUM_TAPS; i++) begin
        active_q[i] <= (i == 0) ? COEF_ONE : '0;
      end
    end else begin
      state_q   <= state_d;
      tap_q     <= tap_d;
      acc_en_q  <= acc_en_d;
      acc_clr_q <= acc_clr_d;
      y_valid_q <= y_valid_d;
      ovf_q     <= ovf_d;
      coef_q    <= active_d[tap_d];
      active_q  <= active_d;
    end
  end

  assign tap_sel = tap_q;
  assign coef    = coef_q;
  assign acc_en  = acc_en_q;
  assign acc_clr = acc_clr_q;
  assign y_valid = y_valid_q;
  assign busy    = (state_q == RUN);
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_ffe_tap_scheduler.sv
// Directed table-driven bench for ffe_tap_scheduler; expectations follow
// the build selected by FFE_SCHED_SHADOW_EN.
module tb_ffe_tap_scheduler;

`ifdef FFE_SCHED_SHADOW_EN
  localparam bit SH = 1'b1;
`else
  localparam bit SH = 1'b0;
`endif

  logic               ffe_clk;
  logic               rst;
  logic               load;
  logic               cfg_we;
  logic [1:0]         cfg_addr;
  logic signed [11:0] cfg_wdata;
  logic               cfg_commit;
  logic               ovf_clr;
  logic               shift_en;
  logic [1:0]         tap_sel;
  logic signed [11:0] coef;
  logic               acc_en;
  logic               acc_clr;
  logic               y_valid;
  logic               busy;
  logic               ovf;
  logic               commit_pending;

  ffe_tap_scheduler #(
    .NUM_TAPS      (4),
    .TAP_IDX_WIDTH (2),
    .COEF_WIDTH    (12)
  ) dut (
    .ffe_clk        (ffe_clk),
    .rst            (rst),
    .load           (load),
    .cfg_we         (cfg_we),
    .cfg_addr       (cfg_addr),
    .cfg_wdata      (cfg_wdata),
    .cfg_commit     (cfg_commit),
    .ovf_clr        (ovf_clr),
    .shift_en       (shift_en),
    .tap_sel        (tap_sel),
    .coef           (coef),
    .acc_en         (acc_en),
    .acc_clr        (acc_clr),
    .y_valid        (y_valid),
    .busy           (busy),
    .ovf            (ovf),
    .commit_pending (commit_pending)
  );

  initial begin
    ffe_clk = 1'b0;
    forever #5 ffe_clk = ~ffe_clk;
  end

  typedef struct {
    bit ld, we;
    int addr, wd;
    bit cm, oc;
    bit e_sh;
    int e_tap, e_coef;
    bit e_en, e_ac, e_yv, e_bz, e_ov, e_pd;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d actual %0d expected %0d", name, step_no, act, exp);
    end
  endtask

  task automatic chk_regs(input vec_t x);
    chk("tap_sel", tap_sel, x.e_tap);
    chk("coef", coef, x.e_coef);
    chk("acc_en", acc_en, x.e_en);
    chk("acc_clr", acc_clr, x.e_ac);
    chk("y_valid", y_valid, x.e_yv);
    chk("busy", busy, x.e_bz);
    chk("ovf", ovf, x.e_ov);
    chk("commit_pending", commit_pending, x.e_pd);
  endtask

  task automatic v(input bit ld, input bit we, input int addr, input int wd,
                   input bit cm, input bit oc, input bit sh, input int tp,
                   input int cf, input bit en, input bit ac, input bit yv,
                   input bit bz, input bit ov, input bit pd);
    vec_t x;
    x.ld = ld; x.we = we; x.addr = addr; x.wd = wd; x.cm = cm; x.oc = oc;
    x.e_sh = sh; x.e_tap = tp; x.e_coef = cf; x.e_en = en; x.e_ac = ac;
    x.e_yv = yv; x.e_bz = bz; x.e_ov = ov; x.e_pd = pd;
    tbl.push_back(x);
  endtask

  // Entered at posedge+1; leaves at the following posedge+1.
  task automatic run_table();
    foreach (tbl[i]) begin
      step_no++;
      load       = tbl[i].ld;
      cfg_we     = tbl[i].we;
      cfg_addr   = 2'(tbl[i].addr);
      cfg_wdata  = 12'(tbl[i].wd);
      cfg_commit = tbl[i].cm;
      ovf_clr    = tbl[i].oc;
      #1;
      chk("shift_en", shift_en, tbl[i].e_sh);
      @(posedge ffe_clk);
      #1;
      chk_regs(tbl[i]);
    end
    tbl.delete();
    load = 0; cfg_we = 0; cfg_commit = 0; ovf_clr = 0;
  endtask

  initial begin
    vec_t rv;
    int cd;

    rv.ld = 0; rv.we = 0; rv.addr = 0; rv.wd = 0; rv.cm = 0; rv.oc = 0;
    rv.e_sh = 0; rv.e_tap = 0; rv.e_coef = 1024; rv.e_en = 0; rv.e_ac = 0;
    rv.e_yv = 0; rv.e_bz = 0; rv.e_ov = 0; rv.e_pd = 0;

    rst = 0; load = 0; cfg_we = 0; cfg_addr = 0; cfg_wdata = 0;
    cfg_commit = 0; ovf_clr = 0;
    repeat (3) @(posedge ffe_clk);
    #2;
    chk_regs(rv);
    chk("shift_en_reset", shift_en, 0);
    @(negedge ffe_clk);
    rst = 1;
    @(posedge ffe_clk);
    #1;

    // single load
    v(1,0,0,0,0,0, 1,0,1024,1,1,0,1,0,0);
    v(0,0,0,0,0,0, 0,1,0,1,0,0,1,0,0);
    v(0,0,0,0,0,0, 0,2,0,1,0,0,1,0,0);
    v(0,0,0,0,0,0, 0,3,0,1,0,0,1,0,0);
    v(0,0,0,0,0,0, 0,0,1024,0,0,1,0,0,0);
    v(0,0,0,0,0,0, 0,0,1024,0,0,0,0,0,0);
    // seven back-to-back loads
    for (int k = 0; k < 7; k++) begin
      v(1,0,0,0,0,0, 1,0,1024,1,1,(k > 0),1,0,0);
      for (int t = 1; t < 4; t++) v(0,0,0,0,0,0, 0,t,0,1,0,0,1,0,0);
    end
    v(0,0,0,0,0,0, 0,0,1024,0,0,1,0,0,0);
    // early loads and ovf handling
    v(1,0,0,0,0,0, 1,0,1024,1,1,0,1,0,0);
    v(0,0,0,0,0,0, 0,1,0,1,0,0,1,0,0);
    v(1,0,0,0,0,0, 0,2,0,1,0,0,1,1,0);
    v(0,0,0,0,0,1, 0,3,0,1,0,0,1,0,0);
    v(1,0,0,0,0,0, 1,0,1024,1,1,1,1,0,0);
    v(1,0,0,0,0,1, 0,1,0,1,0,0,1,1,0);
    v(0,0,0,0,0,0, 0,2,0,1,0,0,1,1,0);
    v(0,0,0,0,0,0, 0,3,0,1,0,0,1,1,0);
    v(0,0,0,0,0,0, 0,0,1024,0,0,1,0,1,0);
    v(0,0,0,0,0,1, 0,0,1024,0,0,0,0,0,0);
    // coefficient writes, commit mid-sample
    cd = SH ? 1024 : 100;
    v(0,1,3,-12,0,0, 0,0,1024,0,0,0,0,0,0);
    v(0,1,2,25,0,0,  0,0,1024,0,0,0,0,0,0);
    v(0,1,1,-50,0,0, 0,0,1024,0,0,0,0,0,0);
    v(0,1,0,100,0,0, 0,0,cd,0,0,0,0,0,0);
    v(1,0,0,0,0,0, 1,0,cd,1,1,0,1,0,0);
    v(0,0,0,0,0,0, 0,1,SH ? 0 : -50,1,0,0,1,0,0);
    v(0,0,0,0,1,0, 0,2,SH ? 0 : 25,1,0,0,1,0,SH);
    v(0,0,0,0,0,0, 0,3,SH ? 0 : -12,1,0,0,1,0,SH);
    v(1,0,0,0,0,0, 1,0,100,1,1,1,1,0,0);
    v(0,0,0,0,0,0, 0,1,-50,1,0,0,1,0,0);
    v(0,0,0,0,0,0, 0,2,25,1,0,0,1,0,0);
    v(0,0,0,0,0,0, 0,3,-12,1,0,0,1,0,0);
    v(0,0,0,0,0,0, 0,0,100,0,0,1,0,0,0);
    // write and commit in the same idle cycle
    v(0,1,2,77,1,0, 0,0,100,0,0,0,0,0,0);
    v(1,0,0,0,0,0, 1,0,100,1,1,0,1,0,0);
    v(0,0,0,0,0,0, 0,1,-50,1,0,0,1,0,0);
    v(0,0,0,0,0,0, 0,2,SH ? 25 : 77,1,0,0,1,0,0);
    v(0,0,0,0,0,0, 0,3,-12,1,0,0,1,0,0);
    v(0,0,0,0,0,0, 0,0,100,0,0,1,0,0,0);
    v(0,0,0,0,1,0, 0,0,100,0,0,0,0,0,0);
    v(1,0,0,0,0,0, 1,0,100,1,1,0,1,0,0);
    v(0,0,0,0,0,0, 0,1,-50,1,0,0,1,0,0);
    v(0,0,0,0,0,0, 0,2,77,1,0,0,1,0,0);
    v(0,0,0,0,0,0, 0,3,-12,1,0,0,1,0,0);
    v(0,0,0,0,0,0, 0,0,100,0,0,1,0,0,0);
    // lead-in to reset at tap 2 with ovf and a pending commit
    v(1,0,0,0,0,0, 1,0,100,1,1,0,1,0,0);
    v(1,0,0,0,1,0, 0,1,-50,1,0,0,1,1,SH);
    v(0,0,0,0,0,0, 0,2,77,1,0,0,1,1,SH);
    run_table();

    // asynchronous reset mid-sample
    step_no++;
    #3;
    rst = 0;
    #2;
    chk_regs(rv);
    #1;
    rst = 1;
    @(posedge ffe_clk);
    #1;

    // no stray y_valid, banks back to passthrough
    v(0,0,0,0,0,0, 0,0,1024,0,0,0,0,0,0);
    v(0,0,0,0,0,0, 0,0,1024,0,0,0,0,0,0);
    v(1,0,0,0,0,0, 1,0,1024,1,1,0,1,0,0);
    v(0,0,0,0,0,0, 0,1,0,1,0,0,1,0,0);
    v(0,0,0,0,0,0, 0,2,0,1,0,0,1,0,0);
    v(0,0,0,0,0,0, 0,3,0,1,0,0,1,0,0);
    v(0,0,0,0,0,0, 0,0,1024,0,0,1,0,0,0);
    run_table();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
